// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the game FSM (master) and the LED pattern engine (slave).
// With LED_PWM_EN defined the bundle also carries the 4-bit brightness duty.
interface led_pattern_gen_if #(
    parameter int LED_W   = 10,
    parameter int FLASH_W = 8
);
    logic               en;
    logic [2:0]         mode;
    logic [FLASH_W-1:0] flash_n;
`ifdef LED_PWM_EN
    logic [3:0]         duty;
`endif
    logic [LED_W-1:0]   ledr;
    logic               phase_tick;
    logic               done;

`ifdef LED_PWM_EN
    modport master (output en, mode, flash_n, duty, input ledr, phase_tick, done);
    modport slave  (input en, mode, flash_n, duty, output ledr, phase_tick, done);
`else
    modport master (output en, mode, flash_n, input ledr, phase_tick, done);
    modport slave  (input en, mode, flash_n, output ledr, phase_tick, done);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern engine: solid/off/blink/chase/bounce/counted flash from one prescaler.
// Optional macro LED_PWM_EN adds a 4-bit duty brightness gate after the pattern register.
module led_pattern_gen #(
    parameter int LED_W       = 10,
    parameter int HALF_PERIOD = 12500000,
    parameter int CNT_W       = 32,
    parameter int FLASH_W     = 8
) (
    input logic              clk,
    input logic              rst,
    led_pattern_gen_if.slave bus
);
    localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(HALF_PERIOD - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LED_W - 1);
    localparam logic [LED_W-1:0] ALL_ON    = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] BIT0      = LED_W'(1);

    localparam logic [2:0] M_SOLID  = 3'd0;
    localparam logic [2:0] M_OFF    = 3'd1;
    localparam logic [2:0] M_BLINK  = 3'd2;
    localparam logic [2:0] M_CHASE  = 3'd3;
    localparam logic [2:0] M_BOUNCE = 3'd4;
    localparam logic [2:0] M_FLASH  = 3'd5;

    logic               init_q, init_d;
    logic [2:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_up_q, dir_up_d;
    logic [FLASH_W-1:0] fcnt_q, fcnt_d;
    logic [FLASH_W-1:0] flash_n_q, flash_n_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;
    logic [LED_W-1:0]   pat_q, pat_d;
    logic               restart, wrap;

    always_comb begin
        // init_q forces a restart on the first cycle out of reset, even if mode matches mode_q
        restart   = init_q || (bus.mode != mode_q);
        wrap      = bus.en && (presc_q == PRESC_MAX);
        init_d    = 1'b0;
        mode_d    = mode_q;
        presc_d   = presc_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        fcnt_d    = fcnt_q;
        flash_n_d = flash_n_q;
        done_d    = done_q;
        tick_d    = 1'b0;
        pat_d     = pat_q;

        if (restart) begin
            mode_d    = bus.mode;
            presc_d   = '0;
            pos_d     = '0;
            dir_up_d  = 1'b1;
            fcnt_d    = '0;
            flash_n_d = bus.flash_n;
            done_d    = 1'b0;
            case (bus.mode)
                M_SOLID:           pat_d = ALL_ON;
                M_CHASE, M_BOUNCE: pat_d = BIT0;
                M_FLASH: begin
                    pat_d  = (bus.flash_n == '0) ? ALL_ON : '0;
                    done_d = (bus.flash_n == '0);
                end
                default:           pat_d = '0;
            endcase
        end else if (bus.en) begin
            presc_d = wrap ? '0 : presc_q + CNT_W'(1);
            if (wrap && !done_q) begin
                tick_d = 1'b1;
                case (mode_q)
                    M_SOLID: pat_d = ALL_ON;
                    M_BLINK: pat_d = ~pat_q;
                    M_CHASE: begin
                        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                        pat_d = BIT0 << pos_d;
                    end
                    M_BOUNCE: begin
                        // Reverse on arrival at an end so each end is shown for one phase only
                        if (LED_W > 1) begin
                            if (dir_up_q && pos_q == POS_LAST) begin
                                pos_d    = pos_q - POS_W'(1);
                                dir_up_d = 1'b0;
                            end else if (!dir_up_q && pos_q == '0) begin
                                pos_d    = POS_W'(1);
                                dir_up_d = 1'b1;
                            end else if (dir_up_q) begin
                                pos_d = pos_q + POS_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                        pat_d = BIT0 << pos_d;
                    end
                    M_FLASH: begin
                        if (pat_q[0]) begin
                            if (fcnt_q + FLASH_W'(1) == flash_n_q) begin
                                done_d = 1'b1;
                            end else begin
                                fcnt_d = fcnt_q + FLASH_W'(1);
                                pat_d  = '0;
                            end
                        end else begin
                            pat_d = ALL_ON;
                        end
                    end
                    default: pat_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q    <= 1'b1;
            mode_q    <= M_OFF;
            presc_q   <= '0;
            pos_q     <= '0;
            dir_up_q  <= 1'b1;
            fcnt_q    <= '0;
            flash_n_q <= '0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
            pat_q     <= '0;
        end else begin
            init_q    <= init_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            fcnt_q    <= fcnt_d;
            flash_n_q <= flash_n_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            pat_q     <= pat_d;
        end
    end

`ifdef LED_PWM_EN
    logic [3:0]       pwm_q, pwm_d;
    logic [LED_W-1:0] ledr_q, ledr_d;

    // Gate with the next counter value so ledr keeps the same one-cycle latency as the pattern
    always_comb begin
        pwm_d  = pwm_q + 4'd1;
        ledr_d = (pwm_d <= bus.duty) ? pat_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q  <= '0;
            ledr_q <= '0;
        end else begin
            pwm_q  <= pwm_d;
            ledr_q <= ledr_d;
        end
    end

    assign bus.ledr = ledr_q;
`else
    assign bus.ledr = pat_q;
`endif
    assign bus.phase_tick = tick_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed + randomized bench for led_pattern_gen against an advance-count reference model.
// Compiles with or without LED_PWM_EN.
module tb_led_pattern_gen;
    localparam int LED_W = 10;
    localparam int HP    = 4;
    localparam int FW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_pattern_gen_if #(.LED_W(LED_W), .FLASH_W(FW)) bus ();

    led_pattern_gen #(.LED_W(LED_W), .HALF_PERIOD(HP), .CNT_W(8), .FLASH_W(FW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: mode in force, advances since restart, enabled cycles since restart
    bit               init_m;
    int               mode_m, k_m, ec_m, fn_m;
    int               pwm_m;
    logic [LED_W-1:0] exp_led;
    logic             exp_tick, exp_done;

    function automatic logic [LED_W-1:0] pattern(int m, int kk, int n);
        int p;
        case (m)
            0: return '1;
            2: return (kk % 2 == 1) ? '1 : '0;
            3: return LED_W'(1) << (kk % LED_W);
            4: begin
                p = kk % (2 * LED_W - 2);
                if (p >= LED_W) p = 2 * LED_W - 2 - p;
                return LED_W'(1) << p;
            end
            5: return (kk >= 2 * n || kk % 2 == 1) ? '1 : '0;
            default: return '0;
        endcase
    endfunction

    function automatic bit finished(int m, int kk, int n);
        return (m == 5) && (kk >= 2 * n);
    endfunction

    task automatic model_update();
        bit gate;
        exp_tick = 1'b0;
        if (rst) begin
            init_m = 1'b1; mode_m = 1; k_m = 0; ec_m = 0; fn_m = 0; pwm_m = 0;
        end else begin
            pwm_m = (pwm_m + 1) % 16;
            if (init_m || int'(bus.mode) != mode_m) begin
                init_m = 1'b0; mode_m = int'(bus.mode); fn_m = int'(bus.flash_n);
                k_m = 0; ec_m = 0;
            end else if (bus.en) begin
                ec_m++;
                if (ec_m % HP == 0 && !finished(mode_m, k_m, fn_m)) begin
                    k_m++;
                    exp_tick = 1'b1;
                end
            end
        end
        exp_led  = rst ? '0 : pattern(mode_m, k_m, fn_m);
        exp_done = !rst && finished(mode_m, k_m, fn_m);
`ifdef LED_PWM_EN
        gate = (pwm_m <= int'(bus.duty));
        if (!gate) exp_led = '0;
`else
        gate = 1'b1;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        n_cmp++;
        assert (bus.ledr === exp_led) else begin
            n_bad++; $error("FAIL ledr: got %h expected %h (t=%0t)", bus.ledr, exp_led, $time);
        end
        n_cmp++;
        assert (bus.phase_tick === exp_tick) else begin
            n_bad++; $error("FAIL phase_tick: got %b expected %b (t=%0t)", bus.phase_tick, exp_tick, $time);
        end
        n_cmp++;
        assert (bus.done === exp_done) else begin
            n_bad++; $error("FAIL done: got %b expected %b (t=%0t)", bus.done, exp_done, $time);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [LED_W-1:0] held;
    int               bound;
    int               ones [LED_W];

    initial begin
        bus.en = 1'b1; bus.mode = 3'd2; bus.flash_n = 8'd3;
`ifdef LED_PWM_EN
        bus.duty = 4'd15;
`endif
        // Reset held 3 cycles with BLINK selected, then free-running blink
        run(3);
        rst = 1'b0;
        run(20);

        bus.mode = 3'd3;          // CHASE through a full wrap
        run(45);
        bus.mode = 3'd4;          // BOUNCE through both ends
        run(80);

        bus.mode = 3'd5; bus.flash_n = 8'd3;
        run(40);
        n_cmp++;
        assert (bus.ledr === 10'h3FF && bus.done === 1'b1) else begin
            n_bad++; $error("FAIL flash3_end: got ledr %h done %b expected 3ff/1", bus.ledr, bus.done);
        end
        bus.mode = 3'd1;
        step();
        bus.mode = 3'd5; bus.flash_n = 8'd0;
        step();
        n_cmp++;
        assert (bus.ledr === 10'h3FF && bus.done === 1'b1) else begin
            n_bad++; $error("FAIL flash0_entry: got ledr %h done %b expected 3ff/1", bus.ledr, bus.done);
        end
        run(10);

        // Freeze in CHASE
        bus.mode = 3'd3;
        run(6);
        bus.en = 1'b0;
        held = bus.ledr;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            assert (bus.ledr === held && bus.phase_tick === 1'b0) else begin
                n_bad++; $error("FAIL freeze: got ledr %h tick %b expected %h/0", bus.ledr, bus.phase_tick, held);
            end
        end
        bus.en = 1'b1;
        run(9);

        // Mode change on the cycle the prescaler would wrap
        bound = 0;
        while (ec_m % HP != HP - 1 && bound < 2 * HP) begin
            step();
            bound++;
        end
        bus.mode = 3'd1;
        step();
        n_cmp++;
        assert (bus.ledr === 10'h000 && bus.phase_tick === 1'b0) else begin
            n_bad++; $error("FAIL wrap_restart: got ledr %h tick %b expected 000/0", bus.ledr, bus.phase_tick);
        end
        run(5);

        // Randomized modes, enables, flash counts and occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) bus.mode = 3'($urandom_range(0, 7));
            bus.flash_n = 8'($urandom_range(0, 4));
            bus.en      = ($urandom_range(0, 9) != 0);
            rst         = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0; bus.en = 1'b1;
        run(2);

`ifdef LED_PWM_EN
        bus.mode = 3'd0; bus.duty = 4'd3;
        run(3);
        for (int b = 0; b < LED_W; b++) ones[b] = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            for (int b = 0; b < LED_W; b++) ones[b] += int'(bus.ledr[b]);
        end
        for (int b = 0; b < LED_W; b++) begin
            n_cmp++;
            assert (ones[b] == 4) else begin
                n_bad++; $error("FAIL pwm_duty3 bit%0d: got %0d lit cycles expected 4", b, ones[b]);
            end
        end
        bus.duty = 4'd15;
        run(16);
`else
        for (int b = 0; b < LED_W; b++) ones[b] = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
